// File: rtl/xor_dec_pkg.sv
// Shared types and constants for the XOR stream decoder.
// Optional parity checking is enabled by defining XOR_DEC_PARITY_EN.
package xor_dec_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int FRAME_LEN_DEF = 16;
    localparam int FRAME_LEN_MIN = 2;
    localparam int FRAME_LEN_MAX = 65535;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/xor_dec_skid.sv
// Two-entry valid/ready skid buffer with registered ready and registered outputs.
// Entry 0 always drives the output; entry 1 absorbs a beat while the consumer stalls.
module xor_dec_skid #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic          o_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);

    logic [DW-1:0] r_e0;
    logic [DW-1:0] r_e1;
    logic [1:0]    r_cnt;
    logic          r_valid;
    logic          r_ready;
    logic          w_pop;
    logic [1:0]    w_cnt_nxt;

    assign w_pop     = r_valid && i_ready;
    assign w_cnt_nxt = r_cnt + {1'b0, i_push} - {1'b0, w_pop};

    // Storage shifts toward entry 0; ready is precomputed from next occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_e0    <= {DW{1'b0}};
            r_e1    <= {DW{1'b0}};
            r_cnt   <= 2'd0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_e0 <= i_data;
                    end else begin
                        r_e1 <= i_data;
                    end
                end
                2'b01: begin
                    r_e0 <= r_e1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_e0 <= i_data;
                    end else begin
                        r_e0 <= r_e1;
                        r_e1 <= i_data;
                    end
                end
                default: begin
                end
            endcase
            r_cnt   <= w_cnt_nxt;
            r_valid <= (w_cnt_nxt != 2'd0);
            r_ready <= (w_cnt_nxt != 2'd2);
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_data  = r_e0;

endmodule

// File: rtl/xor_stream_decoder.sv
// Framed XOR stream decoder (keyed or chained) feeding a 2-entry skid buffer.
// Define XOR_DEC_PARITY_EN to add par_err and end-of-frame parity checking.
module xor_stream_decoder
    import xor_dec_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [WIDTH-1:0] key,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    input  logic             s_sof,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic             err_sync,
`ifdef XOR_DEC_PARITY_EN
    output logic             par_err,
`endif
    output logic [15:0]      frame_cnt
);

`ifdef XOR_DEC_PARITY_EN
    localparam int PW = WIDTH + 2;
`else
    localparam int PW = WIDTH + 1;
`endif
    localparam logic [15:0] LAST_CNT = 16'(FRAME_LEN);

    state_t           r_state;
    logic [WIDTH-1:0] r_hist;
    logic [15:0]      r_cnt;
    logic [15:0]      r_fcnt;
    logic             r_err;

    logic             w_accept;
    logic             w_push;
    logic             w_last;
    logic             w_err;
    logic             w_ready;
    logic             w_valid;
    logic [WIDTH-1:0] w_hist_use;
    logic [WIDTH-1:0] w_dec;
    logic [15:0]      w_cnt_nxt;
    logic [PW-1:0]    w_push_data;
    logic [PW-1:0]    w_pop_data;

    assign w_accept   = s_valid && w_ready;
    // A start-of-frame beat always decodes against a cleared history.
    assign w_hist_use = s_sof ? {WIDTH{1'b0}} : r_hist;
    assign w_dec      = mode ? (s_data ^ key) : (s_data ^ w_hist_use);
    assign w_cnt_nxt  = s_sof ? 16'd1 : (r_cnt + 16'd1);
    assign w_push     = w_accept && (s_sof || (r_state == RUN));
    assign w_last     = w_push && !s_sof && (w_cnt_nxt == LAST_CNT);
    assign w_err      = w_accept && (((r_state == IDLE) && !s_sof) ||
                                     ((r_state == RUN) && s_sof));

`ifdef XOR_DEC_PARITY_EN
    logic [WIDTH-1:0] r_par;
    logic [WIDTH-1:0] w_acc_use;
    logic             w_perr;

    assign w_acc_use   = s_sof ? {WIDTH{1'b0}} : r_par;
    assign w_perr      = w_last && (w_dec != w_acc_use);
    assign w_push_data = {w_perr, w_last, w_dec};

    // Running XOR of decoded bytes in the current frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par <= {WIDTH{1'b0}};
        end else if (w_push) begin
            r_par <= w_acc_use ^ w_dec;
        end else begin
            r_par <= r_par;
        end
    end
`else
    assign w_push_data = {w_last, w_dec};
`endif

    // Framing FSM, beat counter, history and frame counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_hist  <= {WIDTH{1'b0}};
            r_cnt   <= 16'd0;
            r_fcnt  <= 16'd0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_err;
            if (w_push) begin
                r_hist <= s_data;
                r_cnt  <= w_cnt_nxt;
            end
            if (w_last) begin
                r_fcnt <= r_fcnt + 16'd1;
            end
            case (r_state)
                IDLE: begin
                    if (w_push) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_last) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    xor_dec_skid #(
        .DW (PW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_ready (m_ready),
        .o_ready (w_ready),
        .o_valid (w_valid),
        .o_data  (w_pop_data)
    );

    assign s_ready   = w_ready;
    assign m_valid   = w_valid;
    assign m_data    = w_pop_data[WIDTH-1:0];
    assign m_last    = w_pop_data[WIDTH];
`ifdef XOR_DEC_PARITY_EN
    assign par_err   = w_pop_data[WIDTH+1];
`endif
    assign err_sync  = r_err;
    assign frame_cnt = r_fcnt;

endmodule

// File: tb/tb_xor_stream_decoder.sv
// Self-checking bench for xor_stream_decoder: directed tables, corner sequences
// and random traffic against a frame-level reference model.
module tb_xor_stream_decoder;

    localparam int FL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [7:0]  key;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_sof;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic        err_sync;
    logic [15:0] frame_cnt;
`ifdef XOR_DEC_PARITY_EN
    logic        par_err;
`endif

    xor_stream_decoder #(.WIDTH(8), .FRAME_LEN(FL)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .key       (key),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_sof     (s_sof),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .err_sync  (err_sync),
`ifdef XOR_DEC_PARITY_EN
        .par_err   (par_err),
`endif
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       p;
    } beat_t;

    beat_t       q[$];
    bit          in_frame;
    int          fcount;
    logic [7:0]  hist;
    logic [7:0]  acc;
    logic        exp_ready;
    logic        exp_err;
    logic [15:0] exp_fcnt;

    typedef struct {
        logic       sof;
        logic       md;
        logic [7:0] k;
        logic [7:0] e;
        logic [7:0] exp_d;
        logic       exp_l;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        in_frame  = 1'b0;
        fcount    = 0;
        hist      = 8'h00;
        acc       = 8'h00;
        exp_ready = 1'b1;
        exp_err   = 1'b0;
        exp_fcnt  = 16'd0;
    endtask

    // Drive one cycle: compare current outputs with the model, then advance both.
    task automatic cycle(input logic v, input logic sof, input logic md,
                         input logic [7:0] k, input logic [7:0] e, input logic mr);
        logic       acc_ok;
        logic       err;
        logic       lst;
        logic [7:0] d;
        s_valid = v;
        s_sof   = sof;
        mode    = md;
        key     = k;
        s_data  = e;
        m_ready = mr;
        check("s_ready", s_ready, exp_ready);
        check("m_valid", m_valid, q.size() > 0);
        if (q.size() > 0) begin
            check("m_data", m_data, q[0].d);
            check("m_last", m_last, q[0].l);
`ifdef XOR_DEC_PARITY_EN
            if (q[0].l) check("par_err", par_err, q[0].p);
`endif
        end
        check("err_sync", err_sync, exp_err);
        check("frame_cnt", frame_cnt, exp_fcnt);

        acc_ok = v && exp_ready;
        if (q.size() > 0 && mr) void'(q.pop_front());
        err = 1'b0;
        if (acc_ok) begin
            if (sof) begin
                err      = in_frame;
                in_frame = 1'b1;
                fcount   = 1;
                d        = md ? (e ^ k) : e;
                q.push_back('{d, 1'b0, 1'b0});
                hist = e;
                acc  = d;
            end else if (in_frame) begin
                d = md ? (e ^ k) : (e ^ hist);
                fcount++;
                lst = (fcount == FL);
                q.push_back('{d, lst, lst && (d != acc)});
                hist = e;
                acc  = acc ^ d;
                if (lst) begin
                    in_frame = 1'b0;
                    exp_fcnt = exp_fcnt + 16'd1;
                end
            end else begin
                err = 1'b1;
            end
        end
        exp_err   = err;
        exp_ready = (q.size() < 2);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_m_last", m_last, 1'b0);
        check("rst_err_sync", err_sync, 1'b0);
        check("rst_frame_cnt", frame_cnt, 16'd0);
        check("rst_s_ready", s_ready, 1'b1);
`ifdef XOR_DEC_PARITY_EN
        check("rst_par_err", par_err, 1'b0);
`endif
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        rst     = 1'b0;
        mode    = 1'b0;
        key     = 8'h00;
        s_data  = 8'h00;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        m_ready = 1'b1;
        model_reset();

        tbl[0] = '{1'b1, 1'b0, 8'h00, 8'h11, 8'h11, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 8'h33, 8'h22, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 8'h77, 8'h44, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'h88, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 8'hA5, 8'hA5, 8'h00, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'hA5, 8'h00, 8'hA5, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 8'hA5, 8'h5A, 8'hFF, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 8'hA5, 8'hFF, 8'h5A, 1'b1};

        @(negedge clk);
        do_reset();

        // Directed chained and keyed frames.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, tbl[i].sof, tbl[i].md, tbl[i].k, tbl[i].e, 1'b1);
            check("tbl_valid", m_valid, 1'b1);
            check("tbl_data", m_data, tbl[i].exp_d);
            check("tbl_last", m_last, tbl[i].exp_l);
        end
        check("tbl_frame_cnt", frame_cnt, 16'd2);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

        // Backpressure: two beats fill the buffer, the third waits.
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0);
        check("bp_full_ready", s_ready, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0);
        check("bp_stall_data", m_data, 8'h01);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h03, 1'b1);
        check("bp_ready_back", s_ready, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h03, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h04, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

        // Beat without sof in IDLE, then a mid-frame restart.
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h42, 1'b1);
        check("idle_err", err_sync, 1'b1);
        check("idle_drop", m_valid, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        check("idle_err_pulse", err_sync, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 8'h10, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h20, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 8'h30, 1'b1);
        check("trunc_err", err_sync, 1'b1);
        check("trunc_data", m_data, 8'h30);
        check("trunc_no_last", m_last, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h31, 1'b1);
        check("restart_data", m_data, 8'h01);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h32, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h33, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

        // Reset mid-frame with the buffer full.
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 8'hAA, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'hBB, 1'b0);
        check("pre_rst_full", s_ready, 1'b0);
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 8'h5C, 1'b1);
        check("post_rst_data", m_data, 8'h5C);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'(8'h5D + i), 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
